// File: rtl/mean_fb_filter_pkg.sv
// mean_fb_filter_pkg: shared pixel defaults, selection source type and noise classifier
package mean_fb_filter_pkg;
  localparam int DEF_PIX_W = 8;
  localparam int DEF_NOISE_LO = 0;
  localparam int DEF_NOISE_HI = 255;
  localparam int DEF_FB_INIT = 128;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [1:0] {SRC_PASS, SRC_MEAN, SRC_FB} src_e;
  function automatic logic is_noise(input int v, input int lo, input int hi);
    return (v == lo) || (v == hi);
  endfunction
endpackage

// File: rtl/mean_fb_filter_if.sv
// mean_fb_filter_if: input tuple, output pixel and statistics bundle; slave = filter, master = source/sink
interface mean_fb_filter_if #(
  parameter int PIX_W = mean_fb_filter_pkg::DEF_PIX_W,
  parameter int CNT_W = mean_fb_filter_pkg::DEF_CNT_W
);
  logic in_valid;
  logic in_ready;
  logic in_sof;
  logic [PIX_W-1:0] pix_c;
  logic [PIX_W-1:0] pix_n0;
  logic [PIX_W-1:0] pix_n1;
  logic [PIX_W-1:0] pix_n2;
  logic [PIX_W-1:0] pix_n3;
  logic ctr;
  logic out_valid;
  logic out_ready;
  logic [PIX_W-1:0] out_pix;
  logic out_sof;
  logic [CNT_W-1:0] cnt_noisy;
  logic [CNT_W-1:0] cnt_mean;
  logic [CNT_W-1:0] cnt_fb;
  modport slave (
    input in_valid, in_sof, pix_c, pix_n0, pix_n1, pix_n2, pix_n3, ctr, out_ready,
    output in_ready, out_valid, out_pix, out_sof, cnt_noisy, cnt_mean, cnt_fb
  );
  modport master (
    output in_valid, in_sof, pix_c, pix_n0, pix_n1, pix_n2, pix_n3, ctr, out_ready,
    input in_ready, out_valid, out_pix, out_sof, cnt_noisy, cnt_mean, cnt_fb
  );
endinterface

// File: rtl/mean_fb_stat_cnt.sv
// mean_fb_stat_cnt: saturating counter; on en, loads inc when load is set, else increments by inc up to all-ones
module mean_fb_stat_cnt
  import mean_fb_filter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (en) cnt <= load ? CNT_W'(inc) : (inc && cnt != '1) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/mean_fb_filter.sv
// mean_fb_filter: 2-stage salt/pepper corrector (pass, neighbour mean, or feedback) with per-frame counters; ports clk, rst, bus (mean_fb_filter_if.slave)
module mean_fb_filter
  import mean_fb_filter_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int NOISE_LO = DEF_NOISE_LO,
  parameter int NOISE_HI = DEF_NOISE_HI,
  parameter int FB_INIT = DEF_FB_INIT,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  mean_fb_filter_if.slave bus
);
  logic s1_valid, s1_noisy, s1_ctr, s1_sof;
  logic [PIX_W-1:0] s1_c;
  logic [PIX_W+1:0] s1_sum;
  logic s2_noisy, s2_ctr;
  logic [PIX_W-1:0] fb, fb_eff, res;
  logic s2_adv, xfer;
  src_e src;
  assign s2_adv = !bus.out_valid || bus.out_ready;
  assign xfer = bus.out_valid && bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;
  // The pixel leaving stage 2 this cycle is the feedback for the one entering it.
  always_comb begin
    src = !s1_noisy ? SRC_PASS : s1_ctr ? SRC_MEAN : SRC_FB;
    fb_eff = xfer ? bus.out_pix : fb;
    res = src == SRC_PASS ? s1_c :
          src == SRC_MEAN ? PIX_W'(s1_sum >> 2) :
          s1_sof ? PIX_W'(FB_INIT) : fb_eff;
  end
  always_ff @(posedge clk)
    if (rst) s1_valid <= 1'b0;
    else if (bus.in_ready) s1_valid <= bus.in_valid;
  always_ff @(posedge clk)
    if (bus.in_ready && bus.in_valid) begin
      s1_noisy <= is_noise(int'(bus.pix_c), NOISE_LO, NOISE_HI);
      s1_sum <= (PIX_W+2)'(bus.pix_n0) + (PIX_W+2)'(bus.pix_n1) + (PIX_W+2)'(bus.pix_n2) + (PIX_W+2)'(bus.pix_n3);
      s1_c <= bus.pix_c;
      s1_ctr <= bus.ctr;
      s1_sof <= bus.in_sof;
    end
  always_ff @(posedge clk)
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_pix <= '0;
      bus.out_sof <= 1'b0;
      fb <= PIX_W'(FB_INIT);
      s2_noisy <= 1'b0;
      s2_ctr <= 1'b0;
    end else begin
      if (xfer) fb <= bus.out_pix;
      if (s2_adv) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.out_pix <= res;
          bus.out_sof <= s1_sof;
          s2_noisy <= s1_noisy;
          s2_ctr <= s1_ctr;
        end
      end
    end
  mean_fb_stat_cnt #(.CNT_W(CNT_W)) u_cnt_noisy (
    .clk(clk), .rst(rst), .en(xfer), .load(bus.out_sof), .inc(s2_noisy), .cnt(bus.cnt_noisy)
  );
  mean_fb_stat_cnt #(.CNT_W(CNT_W)) u_cnt_mean (
    .clk(clk), .rst(rst), .en(xfer), .load(bus.out_sof), .inc(s2_noisy && s2_ctr), .cnt(bus.cnt_mean)
  );
  mean_fb_stat_cnt #(.CNT_W(CNT_W)) u_cnt_fb (
    .clk(clk), .rst(rst), .en(xfer), .load(bus.out_sof), .inc(s2_noisy && !s2_ctr), .cnt(bus.cnt_fb)
  );
endmodule

// File: tb/tb_mean_fb_filter.sv
// tb_mean_fb_filter: scoreboard bench for mean_fb_filter (16-bit counter instance plus a 4-bit saturation twin)
module tb_mean_fb_filter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mean_fb_filter_if #(.PIX_W(8), .CNT_W(16)) bus ();
  mean_fb_filter_if #(.PIX_W(8), .CNT_W(4)) bus_s ();
  mean_fb_filter #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  mean_fb_filter #(.CNT_W(4)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));
  assign bus_s.in_valid = bus.in_valid;
  assign bus_s.in_sof = bus.in_sof;
  assign bus_s.pix_c = bus.pix_c;
  assign bus_s.pix_n0 = bus.pix_n0;
  assign bus_s.pix_n1 = bus.pix_n1;
  assign bus_s.pix_n2 = bus.pix_n2;
  assign bus_s.pix_n3 = bus.pix_n3;
  assign bus_s.ctr = bus.ctr;
  assign bus_s.out_ready = bus.out_ready;
  typedef struct {
    int pix;
    bit sof;
    int cn, cm, cf, sn, sm, sf;
  } exp_t;
  exp_t q[$];
  exp_t pe;
  bit pend = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int m_cn, m_cm, m_cf, m_sn, m_sm, m_sf;
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int upd(input int v, input bit inc, input bit ld, input int mx);
    return ld ? int'(inc) : (inc && v < mx) ? v + 1 : v;
  endfunction
  task automatic model_reset();
    q.delete();
    m_cn = 0; m_cm = 0; m_cf = 0; m_sn = 0; m_sm = 0; m_sf = 0;
  endtask
  task automatic send(input int c, input int n0, input int n1, input int n2, input int n3,
                      input bit ctr, input bit sof, input int ep);
    exp_t e;
    bit nz;
    int g;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.pix_c = 8'(c);
    bus.pix_n0 = 8'(n0);
    bus.pix_n1 = 8'(n1);
    bus.pix_n2 = 8'(n2);
    bus.pix_n3 = 8'(n3);
    bus.ctr = ctr;
    bus.in_sof = sof;
    #1;
    g = 0;
    while (!bus.in_ready && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready got 0, expected 1 within 200 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    nz = (c == 0) || (c == 255);
    m_cn = upd(m_cn, nz, sof, 65535);
    m_cm = upd(m_cm, nz && ctr, sof, 65535);
    m_cf = upd(m_cf, nz && !ctr, sof, 65535);
    m_sn = upd(m_sn, nz, sof, 15);
    m_sm = upd(m_sm, nz && ctr, sof, 15);
    m_sf = upd(m_sf, nz && !ctr, sof, 15);
    e = '{pix: ep, sof: sof, cn: m_cn, cm: m_cm, cf: m_cf, sn: m_sn, sm: m_sm, sf: m_sf};
    q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int g;
    g = 0;
    while ((q.size() != 0 || pend) && g < 100) begin
      @(negedge clk);
      #2;
      g++;
    end
    if (q.size() != 0 || pend) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d outputs outstanding, expected 0", q.size());
      q.delete();
      pend = 1'b0;
    end
  endtask
  initial begin : monitor
    exp_t e;
    bit stall_prev;
    int held_pix;
    bit held_sof;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pend = 1'b0;
        stall_prev = 1'b0;
        continue;
      end
      if (pend) begin
        chk("cnt_noisy", int'(bus.cnt_noisy), pe.cn);
        chk("cnt_mean", int'(bus.cnt_mean), pe.cm);
        chk("cnt_fb", int'(bus.cnt_fb), pe.cf);
        chk("sat_cnt_noisy", int'(bus_s.cnt_noisy), pe.sn);
        chk("sat_cnt_mean", int'(bus_s.cnt_mean), pe.sm);
        chk("sat_cnt_fb", int'(bus_s.cnt_fb), pe.sf);
        pend = 1'b0;
      end
      if (stall_prev) begin
        chk("stall_valid", int'(bus.out_valid), 1);
        chk("stall_pix", int'(bus.out_pix), held_pix);
        chk("stall_sof", int'(bus.out_sof), int'(held_sof));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got pix %0d, expected no output", bus.out_pix);
        end else begin
          e = q.pop_front();
          chk("out_pix", int'(bus.out_pix), e.pix);
          chk("out_sof", int'(bus.out_sof), int'(e.sof));
          pe = e;
          pend = 1'b1;
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held_pix = int'(bus.out_pix);
      held_sof = bus.out_sof;
    end
  end
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.pix_c = '0;
    bus.pix_n0 = '0;
    bus.pix_n1 = '0;
    bus.pix_n2 = '0;
    bus.pix_n3 = '0;
    bus.ctr = 1'b0;
    bus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_pix", int'(bus.out_pix), 0);
    chk("rst_out_sof", int'(bus.out_sof), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_cnt_noisy", int'(bus.cnt_noisy), 0);
    chk("rst_cnt_mean", int'(bus.cnt_mean), 0);
    chk("rst_cnt_fb", int'(bus.cnt_fb), 0);
    send(100, 1, 2, 3, 4, 1'b0, 1'b1, 100);
    send(255, 10, 20, 30, 41, 1'b1, 1'b0, 25);
    send(90, 0, 0, 0, 0, 1'b0, 1'b0, 90);
    send(0, 0, 0, 0, 0, 1'b0, 1'b0, 90);
    send(0, 0, 0, 0, 0, 1'b0, 1'b1, 128);
    drain();
    fork
      begin
        send(50, 1, 1, 1, 1, 1'b0, 1'b1, 50);
        send(0, 1, 1, 1, 1, 1'b0, 1'b0, 50);
        send(255, 8, 8, 8, 9, 1'b1, 1'b0, 8);
        send(255, 1, 1, 1, 1, 1'b0, 1'b0, 8);
        send(70, 1, 1, 1, 1, 1'b0, 1'b0, 70);
        send(0, 1, 1, 1, 1, 1'b0, 1'b0, 70);
      end
      begin
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("stall_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    send(255, 4, 4, 4, 4, 1'b1, 1'b1, 4);
    for (int i = 0; i < 19; i++) send(255, 4, 4, 4, 4, 1'b1, 1'b0, 4);
    send(60, 4, 4, 4, 4, 1'b1, 1'b1, 60);
    drain();
    send(200, 1, 1, 1, 1, 1'b0, 1'b1, 200);
    send(0, 1, 1, 1, 1, 1'b0, 1'b0, 200);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("postrst_no_output", int'(bus.out_valid), 0);
    end
    chk("postrst_cnt_noisy", int'(bus.cnt_noisy), 0);
    send(0, 1, 1, 1, 1, 1'b0, 1'b0, 128);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
